// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage core. It turns the EX-stage
// branch decision into a registered one-cycle PC redirect that squashes the
// three wrong-path instructions. It also inserts a one-cycle bubble on a
// load-use hazard in ID, and freezes the whole pipeline while data memory
// is busy.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ex_valid          EX holds a real (non-bubble) instruction
//   ex_br_taken       branch unit taken decision (NextPCSrc), from EX
//   ex_br_target      branch/jump target computed in EX
//   ex_mem_read       EX instruction is a load
//   ex_rd             destination register of the EX instruction
//   id_rs1, id_rs2    source registers of the ID instruction
//   id_use_rs1/rs2    ID instruction actually reads rs1 / rs2
//   dmem_busy         data memory not ready, so freeze the pipeline
//   pc_we, pc_sel     PC write enable; PC source select (0 = PC+4, 1 = pc_target)
//   pc_target         registered redirect address
//   if_id_we/flush    IF/ID write enable / clear to bubble
//   id_ex_we/flush    ID/EX write enable / clear to bubble
//   ex_mem_flush      clear EX/MEM to bubble
//   ctrl_state        debug view: 00 RUN, 01 REDIRECT, 10 FREEZE
//
// Optional build macro BRANCH_STATS_EN adds the taken_cnt, stall_cnt and
// squash_cnt performance counters (STATS_W bits wide, wrapping).
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = '0,
    parameter int               STATS_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_br_taken,
    input  logic [XLEN-1:0]   ex_br_target,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [XLEN-1:0]   pc_target,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
`ifdef BRANCH_STATS_EN
    output logic [STATS_W-1:0] taken_cnt,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] squash_cnt,
`endif
    output logic [1:0]        ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_FREEZE   = 2'b10
    } state_t;

    // The register only ever holds RUN or REDIRECT. FREEZE is a combinational
    // overlay, so the pre-freeze state resumes when dmem_busy drops.
    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_target_q;

    logic take;
    logic lu;
    logic run_take;     // RUN-state taken branch: latch target, redirect next
    logic lu_stall;     // RUN-state load-use bubble
    logic redirect_go;  // REDIRECT cycle that actually completes

    always_comb begin
        take = ex_valid & ex_br_taken;
        lu   = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));

        // A taken branch wins over load-use. The ID instruction is wrong-path
        // and gets squashed by the redirect anyway.
        run_take    = !dmem_busy && (state_q == ST_RUN) && take;
        lu_stall    = !dmem_busy && (state_q == ST_RUN) && !take && lu;
        redirect_go = !dmem_busy && (state_q == ST_REDIRECT);
    end

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (run_take) begin
            state_d = ST_REDIRECT;
        end else if (redirect_go) begin
            state_d = ST_RUN;
        end

        if (!rst_n) begin
            // Hold every pipeline register at bubble while reset is asserted.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (dmem_busy) begin
            // Full freeze: nothing written, nothing flushed.
        end else if (state_q == ST_REDIRECT) begin
            pc_we        = 1'b1;
            pc_sel       = 1'b1;
            if_id_we     = 1'b1;
            id_ex_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (lu_stall) begin
            // Hold PC and IF/ID. Write a bubble into ID/EX.
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            id_ex_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_target_q <= PC_RESET;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that all registers update together from pre-edge values.
            state_q <= state_d;
            if (run_take) begin
                pc_target_q <= ex_br_target;
            end
        end
    end

    assign pc_target  = pc_target_q;
    assign ctrl_state = dmem_busy ? ST_FREEZE : state_q;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt  <= '0;
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            // Every qualifier already excludes frozen cycles, so the counters hold during FREEZE.
            if (run_take)    taken_cnt  <= taken_cnt + STATS_W'(1);
            if (lu_stall)    stall_cnt  <= stall_cnt + STATS_W'(1);
            if (redirect_go) squash_cnt <= squash_cnt + STATS_W'(3);
        end
    end
`else
    logic unused_stats_w;
    assign unused_stats_w = ^STATS_W;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_ctrl
//
// Scoreboard bench. The stimulus process drives one input vector per cycle,
// shortly after the rising edge. A reference model works at the level of a
// "redirect pending" flag and a target register, and predicts each cycle's
// outputs. The prediction goes into a queue. A monitor pops the queue on
// every falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    localparam int XLEN = 32;
    localparam logic [31:0] PC_RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_br_taken, ex_mem_read;
    logic [31:0] ex_br_target;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, dmem_busy;
    logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush;
    logic [31:0] pc_target;
    logic [1:0]  ctrl_state;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt, stall_cnt, squash_cnt;
`endif

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.XLEN(XLEN), .PC_RESET(PC_RST), .STATS_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .dmem_busy(dmem_busy),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
`ifdef BRANCH_STATS_EN
        .taken_cnt(taken_cnt), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt),
`endif
        .ctrl_state(ctrl_state)
    );

    typedef struct packed {
        logic        rst;      // 1 = reset asserted
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic        mem_read;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic        busy;
    } stim_t;

    // ctl bit order: pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we,
    // id_ex_flush, ex_mem_flush, ctrl_state[1:0]
    typedef struct {
        logic [8:0]  ctl;
        logic [8:0]  mask;
        logic [31:0] tgt;
        logic [31:0] tk;
        logic [31:0] st;
        logic [31:0] sq;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_taken, m_stall, m_squash;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic lu_hit;
        logic take;
        @(posedge clk);
        #1;
        rst_n        = ~s.rst;
        ex_valid     = s.valid;
        ex_br_taken  = s.taken;
        ex_br_target = s.target;
        ex_mem_read  = s.mem_read;
        ex_rd        = s.rd;
        id_rs1       = s.rs1;
        id_rs2       = s.rs2;
        id_use_rs1   = s.use1;
        id_use_rs2   = s.use2;
        dmem_busy    = s.busy;

        take   = s.valid & s.taken;
        lu_hit = s.mem_read && s.rd != 0 &&
                 ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));

        if (s.rst) begin
            m_pend = 0; m_tgt = PC_RST;
            m_taken = 0; m_stall = 0; m_squash = 0;
        end
        e.tgt = m_tgt; e.tk = m_taken; e.st = m_stall; e.sq = m_squash;
        e.mask = 9'h1FF;

        if (s.rst) begin
            e.ctl  = 9'b0_0_0_1_0_1_1_00;
            e.mask = 9'b1_1_1_1_1_1_1_00;
        end else if (s.busy) begin
            e.ctl = 9'b0_0_0_0_0_0_0_10;
        end else if (m_pend) begin
            // The redirect: PC loads the target and three wrong-path instructions are flushed.
            e.ctl  = 9'b1_1_0_1_0_1_1_01;
            e.mask = 9'b1_1_0_1_0_1_1_11;
            m_pend = 0;
            m_squash += 3;
        end else if (take) begin
            e.ctl  = 9'b1_0_1_0_1_0_0_00;
            m_pend = 1;
            m_tgt  = s.target;
            m_taken += 1;
        end else if (lu_hit) begin
            e.ctl = 9'b0_0_0_0_1_1_0_00;
            m_stall += 1;
        end else begin
            e.ctl = 9'b1_0_1_0_1_0_0_00;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            logic [8:0] act;
            e = sb_q.pop_front();
            act = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                   ex_mem_flush, ctrl_state};
            check("ctl", {23'd0, act & e.mask}, {23'd0, e.ctl & e.mask});
            check("pc_target", pc_target, e.tgt);
`ifdef BRANCH_STATS_EN
            check("taken_cnt", taken_cnt, e.tk);
            check("stall_cnt", stall_cnt, e.st);
            check("squash_cnt", squash_cnt, e.sq);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        ex_valid = 0; ex_br_taken = 0; ex_br_target = 0; ex_mem_read = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; dmem_busy = 0;

        // Reset, then idle cycles.
        s = idle(); s.rst = 1'b1;
        repeat (2) step(s);
        repeat (3) step(idle());

        // Taken branch to 0x40, then the REDIRECT cycle, then RUN.
        s = idle(); s.valid = 1; s.taken = 1; s.target = 32'h0000_0040;
        step(s);
        step(idle());
        step(idle());

        // Load-use on rs2; then the same with ex_rd = 0.
        s = idle(); s.mem_read = 1; s.rd = 5; s.rs2 = 5; s.use2 = 1;
        step(s);
        step(idle());
        s.rd = 0; s.rs2 = 0;
        step(s);

        // Taken branch, then freeze for 3 cycles starting in the REDIRECT cycle.
        s = idle(); s.valid = 1; s.taken = 1; s.target = 32'h0000_1234;
        step(s);
        s = idle(); s.busy = 1;
        repeat (3) step(s);
        step(idle());
        step(idle());

        // Load-use and take together; a second take during REDIRECT is ignored.
        s = idle(); s.valid = 1; s.taken = 1; s.target = 32'h0000_0100;
        s.mem_read = 1; s.rd = 7; s.rs1 = 7; s.use1 = 1;
        step(s);
        s = idle(); s.valid = 1; s.taken = 1; s.target = 32'h0000_0080;
        step(s);
        step(idle());

        // Reset asserted mid-REDIRECT drops the pending redirect.
        s = idle(); s.valid = 1; s.taken = 1; s.target = 32'h0000_0200;
        step(s);
        s = idle(); s.rst = 1'b1;
        step(s);
        repeat (2) step(idle());

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            s.rst      = ($urandom_range(0, 149) == 0);
            s.valid    = ($urandom_range(0, 3) != 0);
            s.taken    = ($urandom_range(0, 4) == 0);
            s.target   = {$urandom_range(0, 32'hFFFF), 2'b00};
            s.mem_read = $urandom_range(0, 1);
            s.rd       = 5'($urandom_range(0, 3));
            s.rs1      = 5'($urandom_range(0, 3));
            s.rs2      = 5'($urandom_range(0, 3));
            s.use1     = $urandom_range(0, 1);
            s.use2     = $urandom_range(0, 1);
            s.busy     = ($urandom_range(0, 5) == 0);
            step(s);
        end
        step(idle());

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
